// File: rtl/rib_arb2.sv
// Two-master to one-slave RIB arbiter: round-robin with lock on stalled address
// phases, plus an in-order ID FIFO that routes slave responses back to their owner.
module rib_arb2 #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  // master 0
  input  logic [31:0] i_ribm0_addr,
  input  logic        i_ribm0_wrcs,
  input  logic [3:0]  i_ribm0_mask,
  input  logic [31:0] i_ribm0_wdata,
  input  logic        i_ribm0_req,
  output logic        o_ribm0_gnt,
  output logic        o_ribm0_rsp,
  input  logic        i_ribm0_rdy,
  output logic [31:0] o_ribm0_rdata,
  // master 1
  input  logic [31:0] i_ribm1_addr,
  input  logic        i_ribm1_wrcs,
  input  logic [3:0]  i_ribm1_mask,
  input  logic [31:0] i_ribm1_wdata,
  input  logic        i_ribm1_req,
  output logic        o_ribm1_gnt,
  output logic        o_ribm1_rsp,
  input  logic        i_ribm1_rdy,
  output logic [31:0] o_ribm1_rdata,
  // shared slave
  output logic [31:0] o_ribs_addr,
  output logic        o_ribs_wrcs,
  output logic [3:0]  o_ribs_mask,
  output logic [31:0] o_ribs_wdata,
  output logic        o_ribs_req,
  input  logic        i_ribs_gnt,
  input  logic        i_ribs_rsp,
  output logic        o_ribs_rdy,
  input  logic [31:0] i_ribs_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          ptr;
  logic          lock_valid;
  logic          lock_id;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          id_mem [DEPTH];

  logic [1:0] req;
  logic [1:0] rdy;
  logic       sel;
  logic       full;
  logic       empty;
  logic       head;
  logic       push;
  logic       pop;

  assign req = {i_ribm1_req, i_ribm0_req};
  assign rdy = {i_ribm1_rdy, i_ribm0_rdy};

  // A stalled master keeps the bus for as long as it keeps requesting.
  // NOTE: sel gets a value on every path, so no latch is inferred.
  always_comb begin
    sel = ptr;
    if (lock_valid && req[lock_id]) sel = lock_id;
    else if (req[ptr])              sel = ptr;
    else                            sel = ~ptr;
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = id_mem[rd_ptr];

  assign o_ribs_req   = i_rstn && !full && req[sel];
  assign o_ribs_addr  = sel ? i_ribm1_addr  : i_ribm0_addr;
  assign o_ribs_wrcs  = sel ? i_ribm1_wrcs  : i_ribm0_wrcs;
  assign o_ribs_mask  = sel ? i_ribm1_mask  : i_ribm0_mask;
  assign o_ribs_wdata = sel ? i_ribm1_wdata : i_ribm0_wdata;

  assign push        = o_ribs_req && i_ribs_gnt;
  assign o_ribm0_gnt = push && !sel;
  assign o_ribm1_gnt = push && sel;

  assign o_ribs_rdy  = !empty && rdy[head];
  assign o_ribm0_rsp = !empty && !head && i_ribs_rsp;
  assign o_ribm1_rsp = !empty && head && i_ribs_rsp;
  assign pop         = i_ribs_rsp && o_ribs_rdy;

  assign o_ribm0_rdata = i_ribs_rdata;
  assign o_ribm1_rdata = i_ribs_rdata;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr        <= 1'b0;
      lock_valid <= 1'b0;
      lock_id    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      if (push) ptr <= ~sel;
      lock_valid <= o_ribs_req && !i_ribs_gnt;
      lock_id    <= sel;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // NOTE: ID storage is not reset; an entry is only read while count says it is valid.
  always_ff @(posedge i_clk) begin
    if (push) id_mem[wr_ptr] <= sel;
  end

endmodule

// File: tb/tb_rib_arb2.sv
// Self-checking bench for rib_arb2: directed scenarios then random traffic, all
// compared every cycle against a queue-based reference model of the arbiter.
module tb_rib_arb2;

  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic [31:0] m_addr  [2];
  logic        m_wrcs  [2];
  logic [3:0]  m_mask  [2];
  logic [31:0] m_wdata [2];
  logic [1:0]  m_req;
  logic [1:0]  m_rdy;
  logic        o_ribm0_gnt, o_ribm1_gnt, o_ribm0_rsp, o_ribm1_rsp;
  logic [31:0] o_ribm0_rdata, o_ribm1_rdata;
  logic [31:0] o_ribs_addr, o_ribs_wdata;
  logic        o_ribs_wrcs, o_ribs_req, o_ribs_rdy;
  logic [3:0]  o_ribs_mask;
  logic        i_ribs_gnt, i_ribs_rsp;
  logic [31:0] i_ribs_rdata;

  int total = 0;
  int bad   = 0;

  // reference model: outstanding owner IDs, preferred master, held selection
  int q[$];
  bit mptr;
  bit lk_v;
  bit lk_id;

  always #5 i_clk = ~i_clk;

  rib_arb2 #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_ribm0_addr(m_addr[0]), .i_ribm0_wrcs(m_wrcs[0]), .i_ribm0_mask(m_mask[0]),
    .i_ribm0_wdata(m_wdata[0]), .i_ribm0_req(m_req[0]), .o_ribm0_gnt(o_ribm0_gnt),
    .o_ribm0_rsp(o_ribm0_rsp), .i_ribm0_rdy(m_rdy[0]), .o_ribm0_rdata(o_ribm0_rdata),
    .i_ribm1_addr(m_addr[1]), .i_ribm1_wrcs(m_wrcs[1]), .i_ribm1_mask(m_mask[1]),
    .i_ribm1_wdata(m_wdata[1]), .i_ribm1_req(m_req[1]), .o_ribm1_gnt(o_ribm1_gnt),
    .o_ribm1_rsp(o_ribm1_rsp), .i_ribm1_rdy(m_rdy[1]), .o_ribm1_rdata(o_ribm1_rdata),
    .o_ribs_addr(o_ribs_addr), .o_ribs_wrcs(o_ribs_wrcs), .o_ribs_mask(o_ribs_mask),
    .o_ribs_wdata(o_ribs_wdata), .o_ribs_req(o_ribs_req), .i_ribs_gnt(i_ribs_gnt),
    .i_ribs_rsp(i_ribs_rsp), .o_ribs_rdy(o_ribs_rdy), .i_ribs_rdata(i_ribs_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mptr  = 1'b0;
    lk_v  = 1'b0;
    lk_id = 1'b0;
  endtask

  // Called just after a rising edge with inputs already applied: checks all
  // outputs against the model, then advances the model across the next edge.
  task automatic step();
    bit         sel;
    bit         e_req, e_rdy, push, pop;
    bit [1:0]   e_gnt, e_rsp;
    #1;
    if (lk_v && m_req[lk_id]) sel = lk_id;
    else if (m_req[mptr])     sel = mptr;
    else                      sel = !mptr;
    e_req = (q.size() < DEPTH) && m_req[sel];
    push  = e_req && i_ribs_gnt;
    e_gnt = 2'b00;
    if (push) e_gnt[sel] = 1'b1;
    e_rsp = 2'b00;
    e_rdy = 1'b0;
    if (q.size() > 0) begin
      e_rdy = m_rdy[q[0]];
      e_rsp[q[0]] = i_ribs_rsp;
    end
    pop = i_ribs_rsp && e_rdy;

    check("ribs_req", {31'd0, o_ribs_req}, {31'd0, e_req});
    check("m0_gnt", {31'd0, o_ribm0_gnt}, {31'd0, e_gnt[0]});
    check("m1_gnt", {31'd0, o_ribm1_gnt}, {31'd0, e_gnt[1]});
    check("m0_rsp", {31'd0, o_ribm0_rsp}, {31'd0, e_rsp[0]});
    check("m1_rsp", {31'd0, o_ribm1_rsp}, {31'd0, e_rsp[1]});
    check("ribs_rdy", {31'd0, o_ribs_rdy}, {31'd0, e_rdy});
    check("m0_rdata", o_ribm0_rdata, i_ribs_rdata);
    check("m1_rdata", o_ribm1_rdata, i_ribs_rdata);
    if (e_req) begin
      check("ribs_addr", o_ribs_addr, m_addr[sel]);
      check("ribs_wrcs", {31'd0, o_ribs_wrcs}, {31'd0, m_wrcs[sel]});
      check("ribs_mask", {28'd0, o_ribs_mask}, {28'd0, m_mask[sel]});
      check("ribs_wdata", o_ribs_wdata, m_wdata[sel]);
    end

    @(posedge i_clk);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(int'(sel));
      mptr = !sel;
    end
    lk_v  = e_req && !i_ribs_gnt;
    lk_id = sel;
    #1;
  endtask

  initial begin
    i_rstn = 1'b0;
    m_req = 2'b00;
    m_rdy = 2'b00;
    i_ribs_gnt = 1'b0;
    i_ribs_rsp = 1'b0;
    i_ribs_rdata = 32'h0;
    for (int m = 0; m < 2; m++) begin
      m_addr[m]  = 32'hA000_0000 + 32'(m);
      m_wrcs[m]  = m[0];
      m_mask[m]  = 4'hF;
      m_wdata[m] = 32'h5500_0000 + 32'(m);
    end
    model_reset();

    // reset state
    #2;
    check("rst_ribs_req", {31'd0, o_ribs_req}, 32'd0);
    check("rst_gnt", {30'd0, o_ribm1_gnt, o_ribm0_gnt}, 32'd0);
    check("rst_rsp", {30'd0, o_ribm1_rsp, o_ribm0_rsp}, 32'd0);
    check("rst_ribs_rdy", {31'd0, o_ribs_rdy}, 32'd0);
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // round robin: alternating grants starting with M0, until FIFO is full
    m_req = 2'b11;
    i_ribs_gnt = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      #1;
      check("rr_gnt0", {31'd0, o_ribm0_gnt}, {31'd0, (k % 2 == 0)});
      check("rr_gnt1", {31'd0, o_ribm1_gnt}, {31'd0, (k % 2 == 1)});
      step();
    end
    #1;
    check("full_block_req", {31'd0, o_ribs_req}, 32'd0);
    step();

    // pop in the same cycle as a pending request: no grant yet
    i_ribs_rsp = 1'b1;
    m_rdy = 2'b11;
    i_ribs_rdata = 32'h1111_0000;
    #1;
    check("pop_rsp0", {31'd0, o_ribm0_rsp}, 32'd1);
    check("pop_same_req", {31'd0, o_ribs_req}, 32'd0);
    check("pop_same_gnt", {30'd0, o_ribm1_gnt, o_ribm0_gnt}, 32'd0);
    step();
    i_ribs_rsp = 1'b0;
    #1;
    check("pop_next_gnt0", {31'd0, o_ribm0_gnt}, 32'd1);
    step();
    #1;
    check("refull_req", {31'd0, o_ribs_req}, 32'd0);
    step();
    m_req = 2'b00;
    i_ribs_gnt = 1'b0;

    // response held while head owner (M1) is not ready
    i_ribs_rsp = 1'b1;
    i_ribs_rdata = 32'hDEAD_BEEF;
    m_rdy = 2'b01;
    repeat (2) begin
      #1;
      check("stall_ribs_rdy", {31'd0, o_ribs_rdy}, 32'd0);
      check("stall_m1_rsp", {31'd0, o_ribm1_rsp}, 32'd1);
      check("stall_m0_rsp", {31'd0, o_ribm0_rsp}, 32'd0);
      check("stall_m1_rdata", o_ribm1_rdata, 32'hDEAD_BEEF);
      step();
    end
    m_rdy = 2'b10;
    #1;
    check("release_ribs_rdy", {31'd0, o_ribs_rdy}, 32'd1);
    step();
    m_rdy = 2'b01;
    i_ribs_rdata = 32'h0BAD_F00D;
    #1;
    check("next_m0_rsp", {31'd0, o_ribm0_rsp}, 32'd1);
    check("next_m1_rsp", {31'd0, o_ribm1_rsp}, 32'd0);
    step();
    m_rdy = 2'b11;
    repeat (2) step();
    i_ribs_rsp = 1'b0;

    // reset with three outstanding IDs, requests still raised
    m_req = 2'b11;
    i_ribs_gnt = 1'b1;
    repeat (3) step();
    i_ribs_rsp = 1'b1;
    #2;
    i_rstn = 1'b0;
    model_reset();
    #1;
    check("arst_ribs_req", {31'd0, o_ribs_req}, 32'd0);
    check("arst_gnt", {30'd0, o_ribm1_gnt, o_ribm0_gnt}, 32'd0);
    check("arst_rsp", {30'd0, o_ribm1_rsp, o_ribm0_rsp}, 32'd0);
    check("arst_ribs_rdy", {31'd0, o_ribs_rdy}, 32'd0);
    m_req = 2'b00;
    i_ribs_gnt = 1'b0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    #1;
    check("stray_rsp", {30'd0, o_ribm1_rsp, o_ribm0_rsp}, 32'd0);
    check("stray_ribs_rdy", {31'd0, o_ribs_rdy}, 32'd0);
    step();
    i_ribs_rsp = 1'b0;

    // stalled M0 keeps the bus while M1 arrives
    m_addr[0] = 32'hF100_0004;
    m_addr[1] = 32'hF200_0008;
    m_req = 2'b01;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) m_req = 2'b11;
      #1;
      check("hold_m0_addr", o_ribs_addr, 32'hF100_0004);
      step();
    end
    i_ribs_gnt = 1'b1;
    #1;
    check("hold_m0_gnt", {31'd0, o_ribm0_gnt}, 32'd1);
    step();
    m_req = 2'b10;
    #1;
    check("then_m1_gnt", {31'd0, o_ribm1_gnt}, 32'd1);
    step();

    // lock holds M1 even though the pointer now prefers M0
    i_ribs_gnt = 1'b0;
    step();
    m_req = 2'b11;
    #1;
    check("lock_m1_addr", o_ribs_addr, 32'hF200_0008);
    step();
    i_ribs_gnt = 1'b1;
    #1;
    check("lock_m1_gnt", {31'd0, o_ribm1_gnt}, 32'd1);
    check("lock_m0_gnt", {31'd0, o_ribm0_gnt}, 32'd0);
    step();
    m_req = 2'b00;
    i_ribs_gnt = 1'b0;
    i_ribs_rsp = 1'b1;
    m_rdy = 2'b11;
    repeat (3) step();
    i_ribs_rsp = 1'b0;

    // random traffic
    repeat (600) begin
      m_req        = 2'($urandom_range(0, 3));
      m_rdy        = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      i_ribs_gnt   = ($urandom_range(0, 2) != 0);
      i_ribs_rsp   = ($urandom_range(0, 1) != 0);
      i_ribs_rdata = $urandom;
      for (int m = 0; m < 2; m++) begin
        m_addr[m]  = $urandom;
        m_wrcs[m]  = $urandom_range(0, 1) != 0;
        m_mask[m]  = 4'($urandom_range(0, 15));
        m_wdata[m] = $urandom;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
